// File: rtl/fbuf_pkg.sv
// Shared definitions for the frame-buffer sequencer: register map, CTRL bit
// positions, sequencing states and the byte-lane write helper.
package fbuf_pkg;

    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_BASE0      = 3'd1;
    localparam logic [2:0] REG_BASE1      = 3'd2;
    localparam logic [2:0] REG_LINEADDR   = 3'd3;
    localparam logic [2:0] REG_LINEWORDS  = 3'd4;
    localparam logic [2:0] REG_NLINES     = 3'd5;
    localparam logic [2:0] REG_FRAMECOUNT = 3'd6;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_SWAP   = 1;
    localparam int unsigned CTRL_ERRCLR = 2;
    localparam int unsigned CTRL_ACTBUF = 4;
    localparam int unsigned CTRL_ERRCNT = 16;

    localparam int unsigned ERRCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        RUN    = 2'd2,
        RESYNC = 2'd3
    } state_t;

    // Merge write data into an existing register value, one byte lane per sel bit
    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = wdat[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/fbuf_sequencer.sv
// Frame-buffer sequencer: Wishbone-programmed shadow geometry, double-buffered
// base address, atomic commit on vsync rise and error-driven resync for imgfifo.
module fbuf_sequencer
    import fbuf_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 24,
    parameter int unsigned LGFLEN        = 11,
    parameter int unsigned LW            = 11
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_we,
    input  logic [2:0]               i_wb_addr,
    input  logic [31:0]              i_wb_data,
    input  logic [3:0]               i_wb_sel,
    output logic                     o_wb_stall,
    output logic                     o_wb_ack,
    output logic [31:0]              o_wb_data,
    input  logic                     i_vsync,
    input  logic                     i_fifo_err,
    output logic                     o_newframe,
    output logic [ADDRESS_WIDTH-1:0] o_baseaddr,
    output logic [ADDRESS_WIDTH-1:0] o_lineaddr,
    output logic [LGFLEN:0]          o_linewords,
    output logic [LW-1:0]            o_nlines,
    output logic                     o_active
);

    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned WW = LGFLEN + 1;

    state_t              state, state_nxt;
    logic                enable, enable_nxt;
    logic                swap_pending, swap_pending_nxt;
    logic                active_buf, active_buf_nxt;
    logic                vsync_q;
    logic [ERRCNT_W-1:0] err_count, err_nxt;
    logic [31:0]         framecount, framecount_nxt;
    logic [AW-1:0]       base0, base0_nxt, base1, base1_nxt;
    logic [AW-1:0]       lineaddr_sh, lineaddr_sh_nxt;
    logic [WW-1:0]       linewords_sh, linewords_sh_nxt;
    logic [LW-1:0]       nlines_sh, nlines_sh_nxt;
    logic [AW-1:0]       baseaddr_nxt, lineaddr_nxt;
    logic [WW-1:0]       linewords_nxt;
    logic [LW-1:0]       nlines_nxt;
    logic                newframe_nxt, active_nxt, ack_nxt;
    logic [31:0]         rdata_nxt, ctrl_rd;
    logic                bus_req, wr_req, swap_set, err_clr, vsync_rise, commit;

    assign o_wb_stall = 1'b0;

    // Bus decode, sequencing and commit
    always_comb begin
        state_nxt        = state;
        enable_nxt       = enable;
        err_nxt          = err_count;
        framecount_nxt   = framecount;
        base0_nxt        = base0;
        base1_nxt        = base1;
        lineaddr_sh_nxt  = lineaddr_sh;
        linewords_sh_nxt = linewords_sh;
        nlines_sh_nxt    = nlines_sh;
        baseaddr_nxt     = o_baseaddr;
        lineaddr_nxt     = o_lineaddr;
        linewords_nxt    = o_linewords;
        nlines_nxt       = o_nlines;
        rdata_nxt        = o_wb_data;
        newframe_nxt     = 1'b0;
        swap_set         = 1'b0;
        err_clr          = 1'b0;
        commit           = 1'b0;
        ctrl_rd          = '0;

        bus_req    = i_wb_cyc & i_wb_stb;
        wr_req     = bus_req & i_wb_we;
        ack_nxt    = bus_req;
        vsync_rise = i_vsync & ~vsync_q;

        ctrl_rd[CTRL_ERRCNT +: ERRCNT_W] = err_count;
        ctrl_rd[CTRL_ACTBUF]             = active_buf;
        ctrl_rd[CTRL_SWAP]               = swap_pending;
        ctrl_rd[CTRL_ENABLE]             = enable;

        if (bus_req) begin
            case (i_wb_addr)
                REG_CTRL:       rdata_nxt = ctrl_rd;
                REG_BASE0:      rdata_nxt = 32'(base0);
                REG_BASE1:      rdata_nxt = 32'(base1);
                REG_LINEADDR:   rdata_nxt = 32'(lineaddr_sh);
                REG_LINEWORDS:  rdata_nxt = 32'(linewords_sh);
                REG_NLINES:     rdata_nxt = 32'(nlines_sh);
                REG_FRAMECOUNT: rdata_nxt = framecount;
                default:        rdata_nxt = '0;
            endcase
        end

        if (wr_req) begin
            case (i_wb_addr)
                REG_CTRL: begin
                    if (i_wb_sel[0]) begin
                        enable_nxt = i_wb_data[CTRL_ENABLE];
                        swap_set   = i_wb_data[CTRL_SWAP];
                        err_clr    = i_wb_data[CTRL_ERRCLR];
                    end
                end
                REG_BASE0:     base0_nxt = AW'(apply_sel(32'(base0), i_wb_data, i_wb_sel));
                REG_BASE1:     base1_nxt = AW'(apply_sel(32'(base1), i_wb_data, i_wb_sel));
                REG_LINEADDR:  lineaddr_sh_nxt  = AW'(apply_sel(32'(lineaddr_sh), i_wb_data, i_wb_sel));
                REG_LINEWORDS: linewords_sh_nxt = WW'(apply_sel(32'(linewords_sh), i_wb_data, i_wb_sel));
                REG_NLINES:    nlines_sh_nxt    = LW'(apply_sel(32'(nlines_sh), i_wb_data, i_wb_sel));
                default: ;
            endcase
        end

        // Disable overrides everything, including a vsync on the same edge
        if (!enable_nxt) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = ARM;
                ARM, RESYNC: begin
                    if (vsync_rise) begin
                        commit    = 1'b1;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (vsync_rise)      commit    = 1'b1;
                    else if (i_fifo_err) state_nxt = RESYNC;
                end
                default: state_nxt = IDLE;
            endcase
        end

        // A swap written on the commit edge survives to the following commit
        swap_pending_nxt = (swap_pending & ~commit) | swap_set;
        active_buf_nxt   = active_buf ^ (commit & swap_pending);

        if (commit) begin
            baseaddr_nxt   = active_buf_nxt ? base1 : base0;
            lineaddr_nxt   = lineaddr_sh;
            linewords_nxt  = linewords_sh;
            nlines_nxt     = nlines_sh;
            newframe_nxt   = 1'b1;
            framecount_nxt = framecount + 32'd1;
        end

        if (err_clr)
            err_nxt = '0;
        else if (i_fifo_err && (state != IDLE) && (err_count != '1))
            err_nxt = err_count + ERRCNT_W'(1);

        active_nxt = (state_nxt == RUN);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            enable       <= 1'b0;
            swap_pending <= 1'b0;
            active_buf   <= 1'b0;
            vsync_q      <= 1'b0;
            err_count    <= '0;
            framecount   <= '0;
            base0        <= '0;
            base1        <= '0;
            lineaddr_sh  <= '0;
            linewords_sh <= '0;
            nlines_sh    <= '0;
            o_baseaddr   <= '0;
            o_lineaddr   <= '0;
            o_linewords  <= '0;
            o_nlines     <= '0;
            o_newframe   <= 1'b0;
            o_active     <= 1'b0;
            o_wb_ack     <= 1'b0;
            o_wb_data    <= '0;
        end else begin
            state        <= state_nxt;
            enable       <= enable_nxt;
            swap_pending <= swap_pending_nxt;
            active_buf   <= active_buf_nxt;
            vsync_q      <= i_vsync;
            err_count    <= err_nxt;
            framecount   <= framecount_nxt;
            base0        <= base0_nxt;
            base1        <= base1_nxt;
            lineaddr_sh  <= lineaddr_sh_nxt;
            linewords_sh <= linewords_sh_nxt;
            nlines_sh    <= nlines_sh_nxt;
            o_baseaddr   <= baseaddr_nxt;
            o_lineaddr   <= lineaddr_nxt;
            o_linewords  <= linewords_nxt;
            o_nlines     <= nlines_nxt;
            o_newframe   <= newframe_nxt;
            o_active     <= active_nxt;
            o_wb_ack     <= ack_nxt;
            o_wb_data    <= rdata_nxt;
        end
    end

endmodule
